// File: rtl/vic_pkg.sv
// vic_pkg: VIC-II cycle-type encodings, chip codes and per-chip line geometry
// Shared by the cycle-type sequencer and the bus arbiter.
package vic_pkg;

    typedef enum logic [1:0] {
        CHIP6569     = 2'd0,
        CHIP6567R56A = 2'd1,
        CHIP6567R8   = 2'd2
    } chip_e;

    // L* = phi-low half accesses, H* = phi-high half accesses
    typedef enum logic [3:0] {
        VIC_LP   = 4'd0,
        VIC_LPI2 = 4'd1,
        VIC_LS2  = 4'd2,
        VIC_LR   = 4'd3,
        VIC_LG   = 4'd4,
        VIC_HS1  = 4'd5,
        VIC_HPI1 = 4'd6,
        VIC_HPI3 = 4'd7,
        VIC_HS3  = 4'd8,
        VIC_HRI  = 4'd9,
        VIC_HRC  = 4'd10,
        VIC_HGC  = 4'd11,
        VIC_HGI  = 4'd12,
        VIC_HI   = 4'd13,
        VIC_LI   = 4'd14,
        VIC_HRX  = 4'd15
    } cycle_e;

    // Unused chip code 3 falls back to PAL geometry.
    function automatic logic [6:0] line_len(input logic [1:0] chip);
        return chip == CHIP6567R8 ? 7'd65 : chip == CHIP6567R56A ? 7'd64 : 7'd63;
    endfunction

    function automatic logic [6:0] sprite0_cycle(input logic [1:0] chip);
        return chip == CHIP6567R8 ? 7'd59 : chip == CHIP6567R56A ? 7'd58 : 7'd57;
    endfunction

    // Phi-high accesses that need the CPU off the address bus.
    function automatic logic is_steal(input logic [3:0] t);
        return t inside {VIC_HS1, VIC_HS3, VIC_HRC, VIC_HGC};
    endfunction

    function automatic logic is_refresh(input logic [3:0] t);
        return t inside {VIC_HRI, VIC_HRC, VIC_HRX};
    endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// bus_arbiter_if: sequencer-to-arbiter bus and the ba/aec handshake pins
// Signals:
//   chip[1:0]           chip code (vic_pkg::chip_e)
//   clk_phi             current phi level
//   phi_phase_start_0   1-tick strobe at the first dot4x tick of each phi half
//   cycle_num[6:0]      0-based cycle within the raster line
//   cycle_type[3:0]     sequencer state (vic_pkg::cycle_e)
//   sprite_dma[N-1:0]   per-sprite DMA enable
//   badline             badline condition, valid at the strobe
//   ba / aec            bus available / address enable control
//   ba_low_cnt[1:0]     phi cycles ba has been low, saturating at 3
//   raster_line[8:0], refc[7:0]  only with REFRESH_ADDR_EN
// Modports: master = sequencer side, slave = arbiter side.
interface bus_arbiter_if #(
    parameter int NUM_SPRITES = 8
);
    logic [1:0]             chip;
    logic                   clk_phi;
    logic                   phi_phase_start_0;
    logic [6:0]             cycle_num;
    logic [3:0]             cycle_type;
    logic [NUM_SPRITES-1:0] sprite_dma;
    logic                   badline;
    logic                   ba;
    logic                   aec;
    logic [1:0]             ba_low_cnt;
`ifdef REFRESH_ADDR_EN
    logic [8:0]             raster_line;
    logic [7:0]             refc;
`endif

    modport master (
        output chip, clk_phi, phi_phase_start_0, cycle_num, cycle_type, sprite_dma, badline,
        input  ba, aec, ba_low_cnt
`ifdef REFRESH_ADDR_EN
        , output raster_line
        , input  refc
`endif
    );

    modport slave (
        input  chip, clk_phi, phi_phase_start_0, cycle_num, cycle_type, sprite_dma, badline,
        output ba, aec, ba_low_cnt
`ifdef REFRESH_ADDR_EN
        , input  raster_line
        , output refc
`endif
    );

endinterface

// File: rtl/ba_window_match.sv
// ba_window_match: flags whether cycle_num lies in one sprite's ba-low span
// Ports:
//   cycle_num_i  current cycle within the line (must be < line length)
//   chip_i       chip code selecting line length and first sprite slot
//   sprite_i     sprite index n
//   in_span_o    1 when cycle_num_i is in (S0+2n-BA_LEAD .. S0+2n+1) mod LINE_LEN
module ba_window_match
    import vic_pkg::*;
#(
    parameter int NUM_SPRITES = 8,
    parameter int BA_LEAD     = 3,
    localparam int IW         = NUM_SPRITES > 1 ? $clog2(NUM_SPRITES) : 1
) (
    input  logic [6:0]    cycle_num_i,
    input  logic [1:0]    chip_i,
    input  logic [IW-1:0] sprite_i,
    output logic          in_span_o
);
    int len, lo, lo_w, d, d_w;

    // The span start can exceed one line length (late sprites on R8), so it is
    // folded once; the distance from the start is then folded once more so the
    // span wraps through cycle 0 without a divider.
    always_comb begin
        len       = int'(line_len(chip_i));
        lo        = int'(sprite0_cycle(chip_i)) + 2 * int'(sprite_i) - BA_LEAD;
        lo_w      = lo >= len ? lo - len : lo;
        d         = int'(cycle_num_i) - lo_w;
        d_w       = d < 0 ? d + len : d;
        in_span_o = d_w <= BA_LEAD + 1;
    end

endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter: turns the sequencer's per-half-cycle view into the ba/aec bus-steal handshake
// Ports:
//   clk_dot4x  4x dot clock, sole clock
//   rst_n      asynchronous active-low reset
//   bus        bus_arbiter_if.slave: sequencer inputs, ba/aec/ba_low_cnt outputs
// Optional feature: REFRESH_ADDR_EN adds the DRAM refresh address counter refc,
// reloaded at raster line 0 cycle 0 and decremented on refresh cycles.
module bus_arbiter
    import vic_pkg::*;
#(
    parameter int NUM_SPRITES = 8,
    parameter int BA_LEAD     = 3,
    localparam int IW         = NUM_SPRITES > 1 ? $clog2(NUM_SPRITES) : 1
) (
    input  logic          clk_dot4x,
    input  logic          rst_n,
    bus_arbiter_if.slave  bus
);
    logic [NUM_SPRITES-1:0] in_span;
    logic                   steal_req, cycle_strobe;
    logic                   ba_q, ba_d, aec_q, aec_d, phase_d1_q, phase_d1_d;
    logic [1:0]             cnt_q, cnt_d;

    for (genvar n = 0; n < NUM_SPRITES; n++) begin : g_win
        ba_window_match #(
            .NUM_SPRITES (NUM_SPRITES),
            .BA_LEAD     (BA_LEAD)
        ) u_win (
            .cycle_num_i (bus.cycle_num),
            .chip_i      (bus.chip),
            .sprite_i    (IW'(n)),
            .in_span_o   (in_span[n])
        );
    end

    // ba and its low counter move once per phi cycle, at the phi-low strobe;
    // aec is settled one tick after each phase strobe so the counter it reads
    // is already updated for this cycle.
    always_comb begin
        steal_req    = |(in_span & bus.sprite_dma) ||
                       (bus.badline && bus.cycle_num inside {[7'd11:7'd53]});
        cycle_strobe = bus.phi_phase_start_0 && !bus.clk_phi;
        ba_d         = cycle_strobe ? !steal_req : ba_q;
        cnt_d        = !cycle_strobe ? cnt_q :
                       !steal_req    ? 2'd0  :
                       cnt_q == 2'd3 ? 2'd3  : cnt_q + 2'd1;
        phase_d1_d   = bus.phi_phase_start_0;
        aec_d        = !phase_d1_q  ? aec_q :
                       !bus.clk_phi ? 1'b0  :
                       !(is_steal(bus.cycle_type) && cnt_q == 2'd3);
    end

    always_ff @(posedge clk_dot4x or negedge rst_n) begin
        if (!rst_n) begin
            ba_q       <= 1'b1;
            aec_q      <= 1'b0;
            cnt_q      <= 2'd0;
            phase_d1_q <= 1'b0;
        end else begin
            ba_q       <= ba_d;
            aec_q      <= aec_d;
            cnt_q      <= cnt_d;
            phase_d1_q <= phase_d1_d;
        end
    end

    assign bus.ba         = ba_q;
    assign bus.aec        = aec_q;
    assign bus.ba_low_cnt = cnt_q;

`ifdef REFRESH_ADDR_EN
    logic [7:0] refc_q, refc_d;
    logic       hi_strobe;

    // The frame-start reload takes priority over a refresh decrement.
    always_comb begin
        hi_strobe = bus.phi_phase_start_0 && bus.clk_phi;
        refc_d    = !hi_strobe ? refc_q :
                    (bus.raster_line == 9'd0 && bus.cycle_num == 7'd0) ? 8'hFF :
                    is_refresh(bus.cycle_type) ? refc_q - 8'd1 : refc_q;
    end

    always_ff @(posedge clk_dot4x or negedge rst_n) begin
        if (!rst_n) begin
            refc_q <= 8'hFF;
        end else begin
            refc_q <= refc_d;
        end
    end

    assign bus.refc = refc_q;
`endif

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: scoreboard bench for bus_arbiter driven by directed line sequences
module tb_bus_arbiter;
    import vic_pkg::*;

    typedef struct packed {
        logic       ba;
        logic       aec;
        logic [1:0] cnt;
        logic [7:0] refc;
        logic [6:0] c;
        logic       hi;
    } exp_t;

    logic clk_dot4x = 1'b0;
    logic rst_n     = 1'b1;

    bus_arbiter_if #(.NUM_SPRITES(8)) bus ();

    bus_arbiter #(.NUM_SPRITES(8), .BA_LEAD(3)) dut (
        .clk_dot4x (clk_dot4x),
        .rst_n     (rst_n),
        .bus       (bus)
    );

    always #5 clk_dot4x = ~clk_dot4x;

    exp_t       sb[$];
    int         tests  = 0;
    int         failed = 0;
    logic [1:0] chip_r   = CHIP6569;
    logic [7:0] dma_r    = 8'h00;
    logic       bl_r     = 1'b0;
    logic [1:0] exp_cnt  = 2'd0;
    logic [7:0] exp_refc = 8'hFF;
`ifdef REFRESH_ADDR_EN
    logic [8:0] raster_r = 9'd0;
`endif

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Sequencer stand-in: phi-high access type for cycle c from the chip tables.
    function automatic logic [3:0] tb_type(input int c);
        int ll, s0;
        ll = chip_r == CHIP6567R8 ? 65 : chip_r == CHIP6567R56A ? 64 : 63;
        s0 = chip_r == CHIP6567R8 ? 59 : chip_r == CHIP6567R56A ? 58 : 57;
        for (int n = 0; n < 8; n++) begin
            if (dma_r[n] && c == (s0 + 2 * n) % ll) return VIC_HS1;
            if (dma_r[n] && c == (s0 + 2 * n + 1) % ll) return VIC_HS3;
        end
        if (c >= 11 && c <= 15) return (bl_r && c >= 14) ? VIC_HRC : VIC_HRI;
        if (bl_r && c >= 16 && c <= 53) return VIC_HGC;
        return VIC_HI;
    endfunction

    // One phi half: 4 dot4x ticks, strobe on the first.
    task automatic half(input int c, input logic hi, input logic [3:0] t);
        @(negedge clk_dot4x);
        bus.chip              = chip_r;
        bus.sprite_dma        = dma_r;
        bus.badline           = bl_r;
        bus.cycle_num         = 7'(c);
        bus.clk_phi           = hi;
        bus.cycle_type        = t;
        bus.phi_phase_start_0 = 1'b1;
`ifdef REFRESH_ADDR_EN
        bus.raster_line       = raster_r;
`endif
        @(negedge clk_dot4x);
        bus.phi_phase_start_0 = 1'b0;
        @(negedge clk_dot4x);
        @(negedge clk_dot4x);
    endtask

    // low = hand-specified "ba is low in this cycle"
    task automatic do_cycle(input int c, input logic low, input logic rst_mid);
        logic [3:0] t;
        exp_t       e;
        t       = tb_type(c);
        exp_cnt = !low ? 2'd0 : exp_cnt == 2'd3 ? 2'd3 : exp_cnt + 2'd1;
        e.ba    = !low;
        e.aec   = 1'b0;
        e.cnt   = exp_cnt;
        e.refc  = exp_refc;
        e.c     = 7'(c);
        e.hi    = 1'b0;
        sb.push_back(e);
        half(c, 1'b0, VIC_LP);
`ifdef REFRESH_ADDR_EN
        if (raster_r == 9'd0 && c == 0) exp_refc = 8'hFF;
        else if (t inside {VIC_HRI, VIC_HRC, VIC_HRX}) exp_refc = exp_refc - 8'd1;
`endif
        e.aec  = !(t inside {VIC_HS1, VIC_HS3, VIC_HRC, VIC_HGC} && exp_cnt == 2'd3);
        e.refc = exp_refc;
        e.hi   = 1'b1;
        sb.push_back(e);
        half(c, 1'b1, t);
        if (rst_mid) begin
            @(posedge clk_dot4x);
            #1 rst_n = 1'b0;
            #1;
            chk("rst_mid_ba", 8'(bus.ba), 8'd1);
            chk("rst_mid_aec", 8'(bus.aec), 8'd0);
            chk("rst_mid_cnt", 8'(bus.ba_low_cnt), 8'd0);
`ifdef REFRESH_ADDR_EN
            chk("rst_mid_refc", bus.refc, 8'hFF);
            exp_refc = 8'hFF;
`endif
            @(negedge clk_dot4x);
            rst_n   = 1'b1;
            exp_cnt = 2'd0;
        end
    endtask

    // Monitor: outputs are settled two ticks after each phase strobe.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk_dot4x);
            if (bus.phi_phase_start_0 === 1'b1) begin
                @(posedge clk_dot4x);
                @(posedge clk_dot4x);
                @(negedge clk_dot4x);
                if (sb.size() == 0) begin
                    chk("sb_underflow", 8'd1, 8'd0);
                end else begin
                    e = sb.pop_front();
                    chk($sformatf("ba c%0d h%0d", e.c, e.hi), 8'(bus.ba), 8'(e.ba));
                    chk($sformatf("aec c%0d h%0d", e.c, e.hi), 8'(bus.aec), 8'(e.aec));
                    chk($sformatf("cnt c%0d h%0d", e.c, e.hi), 8'(bus.ba_low_cnt), 8'(e.cnt));
`ifdef REFRESH_ADDR_EN
                    chk($sformatf("refc c%0d h%0d", e.c, e.hi), bus.refc, e.refc);
`endif
                end
            end
        end
    end

    initial begin
        bus.chip              = CHIP6569;
        bus.clk_phi           = 1'b0;
        bus.phi_phase_start_0 = 1'b0;
        bus.cycle_num         = 7'd0;
        bus.cycle_type        = VIC_LP;
        bus.sprite_dma        = 8'h00;
        bus.badline           = 1'b0;
`ifdef REFRESH_ADDR_EN
        bus.raster_line       = 9'd0;
`endif
        #2 rst_n = 1'b0;
        #2;
        chk("reset_ba", 8'(bus.ba), 8'd1);
        chk("reset_aec", 8'(bus.aec), 8'd0);
        chk("reset_cnt", 8'(bus.ba_low_cnt), 8'd0);
`ifdef REFRESH_ADDR_EN
        chk("reset_refc", bus.refc, 8'hFF);
`endif
        @(negedge clk_dot4x);
        rst_n = 1'b1;

        // 6569, sprite 0 only: ba low 54..58, aec low in high halves of 57/58
        chip_r = CHIP6569;
        dma_r  = 8'h01;
        for (int c = 0; c < 63; c++) do_cycle(c, c >= 54 && c <= 58, 1'b0);

        // badline line: ba low 11..53, steals 14..53
        dma_r = 8'h00;
        bl_r  = 1'b1;
        for (int c = 0; c < 63; c++) do_cycle(c, c >= 11 && c <= 53, 1'b0);

        // badline drops at cycle 30: ba rises at that strobe
        for (int c = 0; c < 63; c++) begin
            if (c == 30) bl_r = 1'b0;
            do_cycle(c, c >= 11 && c <= 29, 1'b0);
        end
        bl_r = 1'b0;

        // R8, all sprites: ba low 56 through the wrap to 9, two lines
        chip_r = CHIP6567R8;
        dma_r  = 8'hFF;
        for (int l = 0; l < 2; l++)
            for (int c = 0; c < 65; c++) do_cycle(c, c >= 56 || c <= 9, 1'b0);

        // sprite 0 enabled late, at the steal cycle: aec never drops
        chip_r = CHIP6569;
        dma_r  = 8'h00;
        for (int c = 0; c < 63; c++) begin
            if (c == 57) dma_r = 8'h01;
            do_cycle(c, c >= 57 && c <= 58, 1'b0);
        end

        // reset pulse in the stolen high half of cycle 57, then a normal line
        for (int c = 0; c < 63; c++) do_cycle(c, c >= 54 && c <= 58, c == 57);
        for (int c = 0; c < 63; c++) do_cycle(c, c >= 54 && c <= 58, 1'b0);

`ifdef REFRESH_ADDR_EN
        // refresh counter: FF at frame start, 5 refreshes per line, wrap 00 -> FF
        dma_r    = 8'h00;
        raster_r = 9'd0;
        for (int c = 0; c < 63; c++) do_cycle(c, 1'b0, 1'b0);
        chk("refc_line0", bus.refc, 8'hFA);
        for (int r = 1; r <= 50; r++) begin
            raster_r = 9'(r);
            for (int c = 10; c <= 16; c++) do_cycle(c, 1'b0, 1'b0);
        end
        chk("refc_zero", bus.refc, 8'h00);
        raster_r = 9'd51;
        for (int c = 10; c <= 11; c++) do_cycle(c, 1'b0, 1'b0);
        chk("refc_wrap", bus.refc, 8'hFF);
`endif

        repeat (4) @(negedge clk_dot4x);
        chk("sb_drain", 8'(sb.size()), 8'd0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
